// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 Hz timing constants and colour field layout.
// Shared by the scan-side controller, the colour generator and the screen bounds logic.
// Constants only; no logic, no latency, no flow control.
package vga_timing_pkg;

    // Horizontal timing, in pixel ticks.
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

    // Vertical timing, in lines.
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

    // Counter widths are fixed by the 800/525 totals.
    localparam int H_CNT_W  = 10;
    localparam int V_CNT_W  = 10;
    localparam int PIX_X_W  = 10;
    localparam int PIX_Y_W  = 9;

    // 12-bit colour word: R[11:8], G[7:4], B[3:0].
    localparam int RGB_W     = 12;
    localparam int RGB_R_MSB = 11;
    localparam int RGB_R_LSB = 8;
    localparam int RGB_G_MSB = 7;
    localparam int RGB_G_LSB = 4;
    localparam int RGB_B_MSB = 3;
    localparam int RGB_B_LSB = 0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_ctrl.sv
// VGA scan timing generator and registered RGB/HSYNC/VSYNC output stage.
// Latency: colour for (x,y) appears on vga_r/g/b one clk after the tick edge that samples it.
// No backpressure: free-running scan, rgb_in must settle within one clk of pix_x/pix_y.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   rgb_in              colour for the current pix_x/pix_y (R[11:8] G[7:4] B[3:0])
//   pix_x, pix_y        active-area coordinates, 0 in blanking
//   pix_valid           counters inside the active area
//   frame_start         one-clk pulse coincident with the counters reading (0,0)
//   vga_r/g/b, vga_hs, vga_vs   registered DAC outputs, syncs active low
module vga_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_valid,
    output logic        frame_start,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             tick;
    logic             h_wrap;
    logic             v_wrap;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             act_nxt;
    logic             in_hsync;
    logic             in_vsync;

    // With CLK_DIV=1 div_cnt is stuck at 0 == DIV_LAST, so tick is constantly high.
    assign tick = (div_cnt == DIV_LAST);

    always_comb begin
        h_wrap   = (h_cnt == H_LAST);
        v_wrap   = (v_cnt == V_LAST);
        h_nxt    = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_nxt    = v_cnt;
        if (h_wrap) begin
            v_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
        end
        act_nxt  = (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
        in_hsync = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        in_vsync = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Coordinates are registered alongside the counters from the next-state
    // values, so pix_x/pix_y/pix_valid leave the block straight from flops.
    // pix_valid doubles as the "current position is active" flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_valid <= 1'b1;
        end else if (tick) begin
            h_cnt     <= h_nxt;
            v_cnt     <= v_nxt;
            pix_valid <= act_nxt;
            pix_x     <= act_nxt ? h_nxt : 10'd0;
            pix_y     <= act_nxt ? v_nxt[8:0] : 9'd0;
        end
    end

    // Colour and syncs share one register stage so they stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else if (tick) begin
            vga_r  <= pix_valid ? rgb_in[vga_timing_pkg::RGB_R_MSB:vga_timing_pkg::RGB_R_LSB] : 4'd0;
            vga_g  <= pix_valid ? rgb_in[vga_timing_pkg::RGB_G_MSB:vga_timing_pkg::RGB_G_LSB] : 4'd0;
            vga_b  <= pix_valid ? rgb_in[vga_timing_pkg::RGB_B_MSB:vga_timing_pkg::RGB_B_LSB] : 4'd0;
            vga_hs <= ~in_hsync;
            vga_vs <= ~in_vsync;
        end
    end

    // Pulses in the clk where the counters first read (0,0); a reset restart
    // does not pass through a wrap tick, so it never produces a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_ctrl.sv
module tb_vga_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        valid;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] col;
    } obs_t;

    typedef struct {
        int d, ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    } cfg_t;

    typedef struct {
        int   n;
        obs_t exp;
    } vec_t;

    localparam cfg_t CA = '{3, 16, 2, 3, 3, 8, 1, 2, 2};
    localparam cfg_t CB = '{1, 16, 2, 3, 3, 8, 1, 2, 2};

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT a: small raster, CLK_DIV=3 ----------------
    logic [11:0] rgb_a, src_a;
    logic [9:0]  pix_x_a;
    logic [8:0]  pix_y_a;
    logic        valid_a, fs_a, hs_a, vs_a;
    logic [3:0]  r_a, g_a, b_a;
    logic        pat_mode = 1'b0;

    assign rgb_a = pat_mode ? {pix_x_a[3:0], pix_y_a[3:0], 4'hA} : src_a;

    vga_ctrl #(.CLK_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
               .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2)) dut_a (
        .clk(clk), .rst(rst_a), .rgb_in(rgb_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
        .pix_valid(valid_a), .frame_start(fs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .vga_hs(hs_a), .vga_vs(vs_a));

    // ---------------- DUT b: small raster, CLK_DIV=1 ----------------
    logic [11:0] rgb_b;
    logic [9:0]  pix_x_b;
    logic [8:0]  pix_y_b;
    logic        valid_b, fs_b, hs_b, vs_b;
    logic [3:0]  r_b, g_b, b_b;

    vga_ctrl #(.CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
               .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2)) dut_b (
        .clk(clk), .rst(rst_b), .rgb_in(rgb_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
        .pix_valid(valid_b), .frame_start(fs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .vga_hs(hs_b), .vga_vs(vs_b));

    // ---------------- DUT f: full 640x480 timing, CLK_DIV=4 ----------------
    logic [11:0] rgb_f = 12'hFFF;
    logic [9:0]  pix_x_f;
    logic [8:0]  pix_y_f;
    logic        valid_f, fs_f, hs_f, vs_f;
    logic [3:0]  r_f, g_f, b_f;

    vga_ctrl dut_f (
        .clk(clk), .rst(rst_b), .rgb_in(rgb_f), .pix_x(pix_x_f), .pix_y(pix_y_f),
        .pix_valid(valid_f), .frame_start(fs_f), .vga_r(r_f), .vga_g(g_f), .vga_b(b_f),
        .vga_hs(hs_f), .vga_vs(vs_f));

    // ---------------- reference model ----------------
    // After n clk edges since reset release, k = n/d ticks have happened and the
    // raster position is k mod (HT*VT). The output stage holds what was sampled
    // at position k-1.
    function automatic obs_t model(cfg_t c, int n, logic [11:0] col);
        obs_t o;
        int ht, vt, ft, k, p, h, v, q, hq, vq;
        logic act;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        ft = ht * vt;
        k  = n / c.d;
        p  = k % ft;
        h  = p % ht;
        v  = p / ht;
        act = (h < c.ha) && (v < c.va);
        o.x     = act ? 10'(h) : 10'd0;
        o.y     = act ? 9'(v) : 9'd0;
        o.valid = act;
        o.col   = col;
        if (k == 0) begin
            o.hs = 1'b1;
            o.vs = 1'b1;
            o.fs = 1'b0;
        end else begin
            q  = (k - 1) % ft;
            hq = q % ht;
            vq = q / ht;
            o.hs = !((hq >= c.ha + c.hfp) && (hq < c.ha + c.hfp + c.hsw));
            o.vs = !((vq >= c.va + c.vfp) && (vq < c.va + c.vfp + c.vsw));
            o.fs = (n % c.d == 0) && (q == ft - 1);
        end
        return o;
    endfunction

    function automatic logic act_at(cfg_t c, int k);
        int ht, vt, p;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        p  = k % (ht * vt);
        return ((p % ht) < c.ha) && ((p / ht) < c.va);
    endfunction

    function automatic obs_t mk(int x, int y, logic valid, logic fs, logic hs, logic vs, logic [11:0] col);
        obs_t o;
        o.x = 10'(x); o.y = 9'(y); o.valid = valid; o.fs = fs; o.hs = hs; o.vs = vs; o.col = col;
        return o;
    endfunction

    function automatic obs_t obs_a();
        return mk(int'(pix_x_a), int'(pix_y_a), valid_a, fs_a, hs_a, vs_a, {r_a, g_a, b_a});
    endfunction

    function automatic obs_t obs_b();
        return mk(int'(pix_x_b), int'(pix_y_b), valid_b, fs_b, hs_b, vs_b, {r_b, g_b, b_b});
    endfunction

    task automatic chk(string name, int n, obs_t got, obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s n=%0d got x=%0d y=%0d valid=%b fs=%b hs=%b vs=%b col=%h want x=%0d y=%0d valid=%b fs=%b hs=%b vs=%b col=%h",
                     name, n, got.x, got.y, got.valid, got.fs, got.hs, got.vs, got.col,
                     exp.x, exp.y, exp.valid, exp.fs, exp.hs, exp.vs, exp.col);
        end
    endtask

    task automatic chk_int(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    // ---------------- stepping ----------------
    int          n_a = 0, n_b = 0;
    logic [11:0] col_a = '0, col_b = '0;
    logic [11:0] hold_a = '0, hold_b = '0;
    logic        rand_a = 1'b0;
    logic        chk_a_en = 1'b0;

    // Choose the next inputs and remember what the next tick edge will sample.
    task automatic record();
        obs_t m;
        src_a = rand_a ? 12'($urandom) : 12'hFFF;
        rgb_b = 12'($urandom);
        if (((n_a + 1) % CA.d) == 0) begin
            m = model(CA, n_a, 12'h0);
            hold_a = pat_mode ? {m.x[3:0], m.y[3:0], 4'hA} : src_a;
        end
        hold_b = rgb_b;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_a) begin
            n_a++;
            if (n_a % CA.d == 0) col_a = act_at(CA, n_a / CA.d - 1) ? hold_a : 12'h0;
        end
        n_b++;
        col_b = act_at(CB, n_b - 1) ? hold_b : 12'h0;
        @(negedge clk);
        chk("b_model", n_b, obs_b(), model(CB, n_b, col_b));
        if (chk_a_en) chk("a_model", n_a, obs_a(), model(CA, n_a, col_a));
        record();
    endtask

    // ---------------- full-timing line measurement ----------------
    logic full_done = 1'b0;

    initial begin
        int cyc, fall1, low;
        cyc = 0;
        wait (rst_b == 1'b0);
        while (hs_f !== 1'b0 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) chk_int("full_col_before_tick", int'({r_f, g_f, b_f}), 0);
            if (cyc == 4) chk_int("full_col_first_pixel", int'({r_f, g_f, b_f}), 12'hFFF);
        end
        fall1 = cyc;
        chk_int("full_hs_fall_clk", fall1, 657 * 4);
        chk_int("full_col_at_hsync", int'({r_f, g_f, b_f}), 0);
        chk_int("full_vs_line0", int'(vs_f), 1);
        low = 0;
        while (hs_f === 1'b0 && low < 1000) begin
            @(negedge clk);
            cyc++;
            low++;
        end
        chk_int("full_hs_low_clk", low, 384);
        while (hs_f !== 1'b0 && cyc < fall1 + 4000) begin
            @(negedge clk);
            cyc++;
        end
        chk_int("full_hs_period_clk", cyc - fall1, 3200);
        full_done = 1'b1;
    end

    // ---------------- main sequence ----------------
    vec_t tbl[17];
    obs_t rst_obs;

    initial begin
        int i, fs_cnt, fs_first, waited;
        logic found;

        rst_obs = mk(0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h0);

        // Directed raster points for DUT a (CLK_DIV=3, 24x13 raster, rgb_in=FFF).
        tbl[0]  = '{0,   mk(0, 0, 1, 0, 1, 1, 12'h000)};
        tbl[1]  = '{2,   mk(0, 0, 1, 0, 1, 1, 12'h000)};
        tbl[2]  = '{3,   mk(1, 0, 1, 0, 1, 1, 12'hFFF)};
        tbl[3]  = '{48,  mk(0, 0, 0, 0, 1, 1, 12'hFFF)};
        tbl[4]  = '{51,  mk(0, 0, 0, 0, 1, 1, 12'h000)};
        tbl[5]  = '{57,  mk(0, 0, 0, 0, 0, 1, 12'h000)};
        tbl[6]  = '{64,  mk(0, 0, 0, 0, 0, 1, 12'h000)};
        tbl[7]  = '{66,  mk(0, 0, 0, 0, 1, 1, 12'h000)};
        tbl[8]  = '{72,  mk(0, 1, 1, 0, 1, 1, 12'h000)};
        tbl[9]  = '{75,  mk(1, 1, 1, 0, 1, 1, 12'hFFF)};
        tbl[10] = '{648, mk(0, 0, 0, 0, 1, 1, 12'h000)};
        tbl[11] = '{651, mk(0, 0, 0, 0, 1, 0, 12'h000)};
        tbl[12] = '{792, mk(0, 0, 0, 0, 1, 0, 12'h000)};
        tbl[13] = '{795, mk(0, 0, 0, 0, 1, 1, 12'h000)};
        tbl[14] = '{936, mk(0, 0, 1, 1, 1, 1, 12'h000)};
        tbl[15] = '{937, mk(0, 0, 1, 0, 1, 1, 12'h000)};
        tbl[16] = '{939, mk(1, 0, 1, 0, 1, 1, 12'hFFF)};

        src_a = 12'hFFF;
        rgb_b = 12'h0;
        repeat (3) @(negedge clk);
        chk("reset_a", 0, obs_a(), rst_obs);
        chk("reset_b", 0, obs_b(), rst_obs);

        rst_a = 1'b0;
        rst_b = 1'b0;
        record();

        for (i = 0; i < 17; i++) begin
            while (n_a < tbl[i].n) step();
            chk("table", n_a, obs_a(), tbl[i].exp);
        end

        // Random colours against the model.
        rand_a   = 1'b1;
        chk_a_en = 1'b1;
        repeat (2000) step();

        // Reset mid-frame at h=10, v=5.
        found = 1'b0;
        for (waited = 0; waited < 1000 && !found; waited++) begin
            if (((n_a / 3) % 24 == 10) && (((n_a / 3) / 24) % 13 == 5)) found = 1'b1;
            else step();
        end
        chk_int("reset_target_reached", int'(found), 1);
        rst_a    = 1'b1;
        chk_a_en = 1'b0;
        #1;
        chk("reset_async", n_a, obs_a(), rst_obs);
        step();
        step();
        chk("reset_hold", n_a, obs_a(), rst_obs);
        rst_a  = 1'b0;
        n_a    = 0;
        col_a  = 12'h0;
        pat_mode = 1'b1;
        record();
        chk("reset_release", n_a, obs_a(), model(CA, 0, 12'h0));
        chk_a_en = 1'b1;

        // Coordinate-driven colour pattern through one wrap; exactly one
        // frame_start, and only at the wrap.
        fs_cnt = 0;
        fs_first = -1;
        repeat (1000) begin
            step();
            if (fs_a) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n_a;
            end
        end
        chk_int("restart_fs_count", fs_cnt, 1);
        chk_int("restart_fs_clk", fs_first, 936);

        waited = 0;
        while (!full_done && waited < 10000) begin
            @(negedge clk);
            waited++;
        end
        chk_int("full_measure_done", int'(full_done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_ctrl.md
# vga_ctrl

VGA 640x480@60 Hz timing generator and output stage: the scan-side counterpart of the pixel colour generator. It produces the pixel coordinates the colour generator consumes, samples the returned 12-bit colour, and drives registered, sync-aligned RGB, HSYNC and VSYNC to the board DAC. It also emits a once-per-frame strobe so game logic can update state during vertical blanking.

## Interface

Parameters:
- CLK_DIV, 4: system clocks per pixel tick (100 MHz → 25 MHz). Legal range 1..16.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixel ticks.
- H_SYNC, 96: horizontal sync width.
- H_BP, 48: horizontal back porch.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width.
- V_BP, 33: vertical back porch.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rgb_in  in  12  colour for the current pix_x/pix_y: R[11:8], G[7:4], B[3:0].
- pix_x  out  10  current horizontal coordinate, 0..639; 0 outside the active area.
- pix_y  out  9  current vertical coordinate, 0..479; 0 outside the active area.
- pix_valid  out  1  high while the counters are inside the active area.
- frame_start  out  1  one-clk pulse at each frame wrap.
- vga_r, vga_g, vga_b  out  4 each  registered colour outputs.
- vga_hs  out  1  horizontal sync, active low.
- vga_vs  out  1  vertical sync, active low.

## Operation

Counters:
- div_cnt counts 0..CLK_DIV-1. tick = (div_cnt == CLK_DIV-1). With CLK_DIV=1, tick is constantly 1.
- h_cnt counts 0..H_TOTAL-1, where H_TOTAL = 800. It advances on tick and wraps to 0.
- v_cnt counts 0..V_TOTAL-1, where V_TOTAL = 525. It advances on tick only when h_cnt wraps, and wraps to 0 itself.

Coordinate outputs (driven directly from registers, no added combinational depth):
- active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
- pix_valid = active.
- pix_x = active ? h_cnt : 0.
- pix_y = active ? v_cnt[8:0] : 0.

Output stage (registered, updates only on tick):
- vga_r/g/b ← active ? rgb_in : 0. Blanking is forced to black whatever rgb_in is.
- vga_hs ← ~(h_cnt ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)), which is [656, 752).
- vga_vs ← ~(v_cnt ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)), which is [490, 492).

frame_start:
- Registered pulse, high for exactly one clk.
- Fires in the cycle after the tick on which h_cnt=799 and v_cnt=524, coincident with the counters reading (0,0).

Reset values:
- div_cnt, h_cnt, v_cnt = 0.
- vga_r/g/b = 0, vga_hs = 1, vga_vs = 1, frame_start = 0.
- Reset asserted mid-frame aborts the frame immediately. After release, scanning restarts at (0,0) with no frame_start pulse for that restart.

## Timing

- rgb_in is treated as combinational from pix_x/pix_y. It must settle within one clk; it is sampled only on the tick edge.
- Latency: the colour for coordinate (x,y) appears on vga_r/g/b one clk after the tick edge that sampled it. HSYNC and VSYNC use the identical register stage, so colour and syncs stay mutually aligned.
- pix_x/pix_y stay constant for CLK_DIV clocks per pixel.
- Line period: 800 ticks = 800·CLK_DIV clk.
- Frame period: 420 000 ticks. At CLK_DIV=4 that is 1 680 000 clk.
- Simultaneous h and v wrap: both counters go to 0 on the same tick; no intermediate (0,524) or (799,0) state is visible.
- All widths are fixed by the 800/525 totals: h_cnt is 10 bits, v_cnt is 10 bits, and pix_y truncates v_cnt to 9 bits, which is only valid while active.

## Structure

- Shared package/header vga_timing_pkg holds:
  - H_ACTIVE, H_FP, H_SYNC, H_BP, H_TOTAL;
  - V_ACTIVE, V_FP, V_SYNC, V_BP, V_TOTAL;
  - the 12-bit colour field positions, also used by the colour generator and the screen bounds logic.
- No sub-module. div_cnt, h_cnt, v_cnt and the output register stage all live in vga_ctrl. Target roughly 150 lines.

## Test plan

- **Reset mid-frame:** assert rst at h=300, v=200 → all outputs take reset values asynchronously; after release pix_x=0, pix_y=0, pix_valid=1; no frame_start until the next wrap.
- **Line and sync timing (CLK_DIV=4):** measure vga_hs → low for 384 clk, period 3200 clk, falling edge at h=656 plus one clk.
- **Frame and vsync timing:** vga_vs low for 2 lines (6400 clk), starting at line 490; frame_start period exactly 1 680 000 clk, one clk wide.
- **Blanking:** hold rgb_in=12'hFFF → vga_r/g/b = F only while active, 0 at h≥640 or v≥480; pix_x=pix_y=0 and pix_valid=0 in blanking.
- **Colour latency:** drive rgb_in = {pix_x[3:0], pix_y[3:0], 4'hA} → output at the tick after (x,y) equals that pattern, aligned with the syncs.
- **CLK_DIV=1:** tick every cycle → line = 800 clk, frame = 420 000 clk, coordinates advance every clk.
